// File: rtl/network_sequencer_if.sv
// network_sequencer_if: groups the control, spike and classification signals
// of network_sequencer. The master modport drives enable/start/window_len/
// spikes_in; the slave modport (the sequencer) returns the layer enables,
// the output-valid strobe, the spike counters and the classification result.
interface network_sequencer_if #(
    parameter int NUM_LAYERS = 3,
    parameter int N          = 8,
    parameter int CNT_W      = 8,
    parameter int WIN_W      = 8
);
    localparam int CLS_W = (N > 1) ? $clog2(N) : 1;

    logic                   enable;
    logic                   start;
    logic [WIN_W-1:0]       window_len;
    logic [N-1:0]           spikes_in;
    logic [NUM_LAYERS-1:0]  layer_enable;
    logic                   output_data_ready;
    logic [N*CNT_W-1:0]     spike_counts;
    logic [CLS_W-1:0]       class_out;
    logic                   class_valid;
    logic                   busy;

    modport master (
        output enable, start, window_len, spikes_in,
        input  layer_enable, output_data_ready, spike_counts,
               class_out, class_valid, busy
    );

    modport slave (
        input  enable, start, window_len, spikes_in,
        output layer_enable, output_data_ready, spike_counts,
               class_out, class_valid, busy
    );
endinterface

// File: rtl/network_sequencer.sv
// network_sequencer: staggers enables through NUM_LAYERS cascaded layers,
// counts final-layer spikes over a window of output-valid samples, then
// scans the counters one neuron per cycle and reports the winning index.
// Optional macro SPIKE_CNT_SATURATE_EN: counters saturate at 2^CNT_W-1
// instead of wrapping.
module network_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int N          = 8,
    parameter int CNT_W      = 8,
    parameter int WIN_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    network_sequencer_if.slave   bus
);
    localparam int CLS_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DECIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                state_r;
    logic [CNT_W-1:0]      cnt_r [N];
    logic [WIN_W-1:0]      win_r;
    logic [WIN_W-1:0]      samp_r;
    logic [CLS_W-1:0]      scan_r;
    logic [CLS_W-1:0]      best_idx_r;
    logic [CNT_W-1:0]      best_cnt_r;
    logic [CLS_W-1:0]      class_r;
    logic                  valid_r;
    logic                  busy_r;
    logic                  ready_r;
    logic [NUM_LAYERS-1:0] le_s;
    logic [CNT_W-1:0]      cand_s;
    logic [CLS_W-1:0]      nb_idx_s;
    logic [CNT_W-1:0]      nb_cnt_s;
    logic [N*CNT_W-1:0]    counts_s;
    logic                  last_samp_s;

    // Adds one spike to a counter, wrapping or saturating on overflow.
    function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] c,
                                                 input logic spk);
`ifdef SPIKE_CNT_SATURATE_EN
        if (spk && (c != {CNT_W{1'b1}})) begin
            return c + CNT_W'(1);
        end else begin
            return c;
        end
`else
        return c + CNT_W'(spk);
`endif
    endfunction

    // Layer 0 follows enable directly; each deeper layer is one register later.
    generate
        if (NUM_LAYERS > 1) begin : g_pipe
            logic [NUM_LAYERS-1:1] pipe_r;

            // Shift the enable one layer deeper per clock.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pipe_r <= '0;
                end else begin
                    pipe_r <= le_s[NUM_LAYERS-2:0];
                end
            end

            assign le_s = {pipe_r, bus.enable};
        end else begin : g_nopipe
            assign le_s = bus.enable;
        end
    endgenerate

    // Final-layer output is valid one clock after the last layer is enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= le_s[NUM_LAYERS-1];
        end
    end

    // Compare the neuron under scan against the running best (strictly greater wins).
    always_comb begin
        cand_s   = cnt_r[scan_r];
        nb_idx_s = best_idx_r;
        nb_cnt_s = best_cnt_r;
        if (cand_s > best_cnt_r) begin
            nb_idx_s = scan_r;
            nb_cnt_s = cand_s;
        end else begin
            nb_idx_s = best_idx_r;
            nb_cnt_s = best_cnt_r;
        end
    end

    // Detect that the sample about to be taken closes the window.
    always_comb begin
        last_samp_s = (({1'b0, samp_r} + {{WIN_W{1'b0}}, 1'b1}) == {1'b0, win_r});
    end

    // Window sequencing FSM: accept start, count samples, scan, report.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= '0;
            end
            win_r      <= '0;
            samp_r     <= '0;
            scan_r     <= '0;
            best_idx_r <= '0;
            best_cnt_r <= '0;
            class_r    <= '0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (bus.start) begin
                        for (int i = 0; i < N; i++) begin
                            cnt_r[i] <= '0;
                        end
                        samp_r  <= '0;
                        win_r   <= (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if (ready_r) begin
                        for (int i = 0; i < N; i++) begin
                            cnt_r[i] <= cnt_add(cnt_r[i], bus.spikes_in[i]);
                        end
                        samp_r <= samp_r + WIN_W'(1);
                        if (last_samp_s) begin
                            scan_r     <= '0;
                            best_idx_r <= '0;
                            best_cnt_r <= '0;
                            state_r    <= DECIDE;
                        end
                    end
                end
                DECIDE: begin
                    best_idx_r <= nb_idx_s;
                    best_cnt_r <= nb_cnt_s;
                    scan_r     <= scan_r + CLS_W'(1);
                    if (scan_r == CLS_W'(N - 1)) begin
                        class_r <= nb_idx_s;
                        valid_r <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Pack the per-neuron counters onto the flat output bus.
    always_comb begin
        counts_s = '0;
        for (int i = 0; i < N; i++) begin
            counts_s[i*CNT_W +: CNT_W] = cnt_r[i];
        end
    end

    assign bus.layer_enable      = le_s;
    assign bus.output_data_ready = ready_r;
    assign bus.spike_counts      = counts_s;
    assign bus.class_out         = class_r;
    assign bus.class_valid       = valid_r;
    assign bus.busy              = busy_r;
endmodule
